// File: rtl/adc_seq_pkg.sv
// rtl/adc_seq_pkg.sv - shared constants and FSM state type for the ADC scan sequencer
package adc_seq_pkg;

  localparam int CHAN_W          = 5;
  localparam int DATA_W          = 12;
  localparam int ACC_W           = 14;
  localparam int DEFAULT_TIMEOUT = 255;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    CMD,
    WAIT,
    STORE
  } seq_state_t;

endpackage

// File: rtl/adc_seq_arb.sv
// rtl/adc_seq_arb.sv - scan slot index and scan/request round-robin arbitration
module adc_seq_arb #(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_arb,
  input  logic              i_scan_en,
  input  logic              i_req_valid,
  input  logic              i_advance,
  output logic              o_grant_scan,
  output logic              o_grant_req,
  output logic              o_last_scan,
  output logic [SLOT_W-1:0] o_slot
);

  logic              r_last_scan;
  logic [SLOT_W-1:0] r_slot;

  // A request only yields to scanning when the previous grant already went to it.
  always_comb begin
    o_grant_req  = i_arb && i_req_valid && (r_last_scan || !i_scan_en);
    o_grant_scan = i_arb && i_scan_en && !o_grant_req;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last_scan <= 1'b0;
      r_slot      <= '0;
    end else begin
      if (o_grant_scan) begin
        r_last_scan <= 1'b1;
      end else if (o_grant_req) begin
        r_last_scan <= 1'b0;
      end
      if (i_advance) begin
        r_slot <= (r_slot == SLOT_W'(NUM_SLOTS - 1)) ? '0 : r_slot + 1'b1;
      end
    end
  end

  assign o_last_scan = r_last_scan;
  assign o_slot      = r_slot;

endmodule

// File: rtl/adc_scan_sequencer.sv
// rtl/adc_scan_sequencer.sv - round-robin ADC slot scanner with one-shot request port
// ADC_SCAN_AVG_EN: each scan grant averages four back-to-back conversions.
module adc_scan_sequencer
  import adc_seq_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
  input  logic                          clock_clk,
  input  logic                          reset_sink_reset,
  input  logic                          scan_en,
  input  logic [NUM_SLOTS*CHAN_W-1:0]   slot_chan,
  input  logic                          req_valid,
  input  logic [CHAN_W-1:0]             req_channel,
  output logic                          req_ready,
  output logic                          rsp_valid,
  output logic [DATA_W-1:0]             rsp_data,
  output logic                          command_valid,
  output logic [CHAN_W-1:0]             command_channel,
  output logic                          command_startofpacket,
  output logic                          command_endofpacket,
  input  logic                          command_ready,
  input  logic                          response_valid,
  input  logic [CHAN_W-1:0]             response_channel,
  input  logic [DATA_W-1:0]             response_data,
  output logic [NUM_SLOTS*DATA_W-1:0]   sample_data,
  output logic [NUM_SLOTS-1:0]          sample_fresh,
  output logic                          timeout_err
);

  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  seq_state_t         r_state, w_next;
  logic [CHAN_W-1:0]  r_chan;
  logic [7:0]         r_tmo;
  logic [DATA_W-1:0]  r_sample [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] r_fresh;
  logic [DATA_W-1:0]  r_rsp_data;
  logic               r_timeout_err;
  logic [CHAN_W-1:0]  w_slot_chan [NUM_SLOTS];
  logic               w_grant_scan, w_grant_req, w_last_scan, w_advance;
  logic [SLOT_W-1:0]  w_slot;
  logic               w_match, w_tmo_hit, w_last_conv;
  logic [DATA_W-1:0]  w_store_data;

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
    assign w_slot_chan[k]                   = slot_chan[k*CHAN_W +: CHAN_W];
    assign sample_data[k*DATA_W +: DATA_W]  = r_sample[k];
  end

  assign w_match   = (r_state == WAIT) && response_valid && (response_channel == r_chan);
  assign w_tmo_hit = (r_state == WAIT) && !w_match && (r_tmo == 8'(TIMEOUT - 1));
  assign w_advance = w_last_scan && ((r_state == STORE) || w_tmo_hit);

  adc_seq_arb #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_W    (SLOT_W)
  ) u_arb (
    .i_clk        (clock_clk),
    .i_reset      (reset_sink_reset),
    .i_arb        (r_state == ARB),
    .i_scan_en    (scan_en),
    .i_req_valid  (req_valid),
    .i_advance    (w_advance),
    .o_grant_scan (w_grant_scan),
    .o_grant_req  (w_grant_req),
    .o_last_scan  (w_last_scan),
    .o_slot       (w_slot)
  );

`ifdef ADC_SCAN_AVG_EN
  logic [1:0]       r_conv;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_sum;

  assign w_sum        = r_acc + ACC_W'(response_data);
  assign w_last_conv  = !w_last_scan || (r_conv == 2'd3);
  assign w_store_data = w_sum[ACC_W-1:2];

  always_ff @(posedge clock_clk) begin
    if (reset_sink_reset || w_grant_scan) begin
      r_conv <= '0;
      r_acc  <= '0;
    end else if (w_match && w_last_scan) begin
      r_conv <= r_conv + 2'd1;
      r_acc  <= w_sum;
    end
  end
`else
  assign w_last_conv  = 1'b1;
  assign w_store_data = response_data;
`endif

  always_ff @(posedge clock_clk) begin
    if (reset_sink_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next                = r_state;
    req_ready             = 1'b0;
    rsp_valid             = 1'b0;
    command_valid         = 1'b0;
    command_startofpacket = 1'b0;
    command_endofpacket   = 1'b0;
    case (r_state)
      IDLE: if (scan_en || req_valid) w_next = ARB;
      ARB: begin
        req_ready = w_grant_req;
        w_next    = (w_grant_req || w_grant_scan) ? CMD : IDLE;
      end
      CMD: begin
        command_valid         = 1'b1;
        command_startofpacket = 1'b1;
        command_endofpacket   = 1'b1;
        if (command_ready) w_next = WAIT;
      end
      WAIT: begin
        if (w_match) begin
          w_next = w_last_conv ? STORE : CMD;
        end else if (w_tmo_hit) begin
          w_next = ARB;
        end
      end
      STORE: begin
        rsp_valid = !w_last_scan;
        w_next    = ARB;
      end
      default: w_next = IDLE;
    endcase
  end

  // Results land as STORE is entered so they are visible for the whole STORE cycle.
  always_ff @(posedge clock_clk) begin
    if (reset_sink_reset) begin
      r_chan        <= '0;
      r_tmo         <= '0;
      r_fresh       <= '0;
      r_rsp_data    <= '0;
      r_timeout_err <= 1'b0;
      for (int k = 0; k < NUM_SLOTS; k++) r_sample[k] <= '0;
    end else begin
      if (w_grant_scan) begin
        r_chan          <= w_slot_chan[w_slot];
        r_fresh[w_slot] <= 1'b0;
      end else if (w_grant_req) begin
        r_chan <= req_channel;
      end
      if (r_state == CMD) begin
        r_tmo <= '0;
      end else if (r_state == WAIT) begin
        r_tmo <= r_tmo + 8'd1;
      end
      if (w_tmo_hit) r_timeout_err <= 1'b1;
      if (w_match && !w_last_scan) r_rsp_data <= response_data;
      if (w_match && w_last_scan && w_last_conv) begin
        r_sample[w_slot] <= w_store_data;
        r_fresh[w_slot]  <= 1'b1;
      end
    end
  end

  assign command_channel = r_chan;
  assign rsp_data        = r_rsp_data;
  assign sample_fresh    = r_fresh;
  assign timeout_err     = r_timeout_err;

endmodule
